// File: rtl/sm_trace_buffer.sv
// rtl/sm_trace_buffer.sv - triggered PC/instruction trace buffer with post-trigger window and timeout
module sm_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT   = 120,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          sampleEn,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic [31:0]   trigPc,
  input  logic [AW-1:0] rdIdx,
  output logic [31:0]   rdPc,
  output logic [31:0]   rdInstr,
  output logic [AW:0]   count,
  output logic [AW-1:0] trigPos,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_cyc;
  logic [AW-1:0] r_post;
  logic [AW-1:0] r_ptaken;
  logic          r_trig_seen;
  logic [AW-1:0] r_trig_pos;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [31:0]   r_rd_pc;
  logic [31:0]   r_rd_instr;
  logic [63:0]   r_mem [DEPTH];

  logic          w_cap;
  logic          w_wr;
  logic          w_hit;
  logic          w_complete;
  logic          w_tmo;
  logic [AW:0]   w_cnt_nxt;
  logic [AW-1:0] w_ptaken_nxt;
  logic          w_trig_seen_nxt;
  logic [AW-1:0] w_tpos_nxt;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_valid;

  // Capture-cycle event decode and next-state selection; completion beats timeout
  always_comb begin
    w_cap           = (r_state == S_ARMED) || (r_state == S_POST);
    w_wr            = w_cap && sampleEn;
    w_hit           = (r_state == S_ARMED) && w_wr && (pc == trigPc);
    w_complete      = ((r_state == S_POST) && w_wr && (r_post == AW'(1))) ||
                      (w_hit && (POST_TRIG == 0));
    w_tmo           = w_cap && (r_cyc == 16'(TIMEOUT - 1)) && !w_complete;
    w_cnt_nxt       = (w_wr && (r_count != (AW+1)'(DEPTH))) ? r_count + (AW+1)'(1) : r_count;
    w_ptaken_nxt    = r_ptaken + AW'((r_state == S_POST) && w_wr);
    w_trig_seen_nxt = r_trig_seen || w_hit;
    // Trigger entry sits (samples after it) below the newest entry; modular AW math handles full count
    w_tpos_nxt      = w_trig_seen_nxt ? (w_cnt_nxt[AW-1:0] - AW'(1) - w_ptaken_nxt) : '0;
    w_state_nxt     = r_state;
    if (w_cap) begin
      if (w_complete || w_tmo) begin
        w_state_nxt = S_DONE;
      end else if (w_hit) begin
        w_state_nxt = S_POST;
      end
    end
    w_rd_addr  = r_wr_ptr - r_count[AW-1:0] + rdIdx;
    w_rd_valid = ({1'b0, rdIdx} < r_count);
  end

  // Control state: arm restarts from any state and overrides every other event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      r_post      <= '0;
      r_ptaken    <= '0;
      r_trig_seen <= 1'b0;
      r_trig_pos  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (arm) begin
      r_state     <= S_ARMED;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      r_post      <= '0;
      r_ptaken    <= '0;
      r_trig_seen <= 1'b0;
      r_trig_pos  <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_cap) begin
      r_state     <= w_state_nxt;
      r_count     <= w_cnt_nxt;
      r_cyc       <= r_cyc + 16'd1;
      r_ptaken    <= w_ptaken_nxt;
      r_trig_seen <= w_trig_seen_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_hit) begin
        r_post <= AW'(POST_TRIG);
      end else if ((r_state == S_POST) && w_wr) begin
        r_post <= r_post - AW'(1);
      end
      if (w_state_nxt == S_DONE) begin
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_timeout  <= w_tmo;
        r_trig_pos <= w_tpos_nxt;
      end
    end
  end

  // Trace storage; contents are never cleared, visibility is governed by count
  always_ff @(posedge clk) begin
    if (!arm && w_wr) begin
      r_mem[r_wr_ptr] <= {pc, instr};
    end
  end

  // Registered readout, oldest-relative; indices beyond count read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
    end else if (w_rd_valid) begin
      r_rd_pc    <= r_mem[w_rd_addr][63:32];
      r_rd_instr <= r_mem[w_rd_addr][31:0];
    end else begin
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
    end
  end

  assign rdPc    = r_rd_pc;
  assign rdInstr = r_rd_instr;
  assign count   = r_count;
  assign trigPos = r_trig_pos;
  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb/tb_sm_trace_buffer.sv - directed self-checking bench for sm_trace_buffer
module tb_sm_trace_buffer;

  localparam logic [31:0] IXOR = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        sampleEn;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] trigPc;
  logic [2:0]  rdIdx;
  logic [31:0] rdPc;
  logic [31:0] rdInstr;
  logic [3:0]  count;
  logic [2:0]  trigPos;
  logic        busy;
  logic        done;
  logic        timeout;

  int total;
  int bad;
  int n;

  sm_trace_buffer #(.DEPTH(8), .POST_TRIG(3), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .sampleEn(sampleEn), .pc(pc),
    .instr(instr), .trigPc(trigPc), .rdIdx(rdIdx), .rdPc(rdPc),
    .rdInstr(rdInstr), .count(count), .trigPos(trigPos), .busy(busy),
    .done(done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse arm; returns at the negedge where the DUT is ARMED
  task automatic do_arm(input logic [31:0] tp);
    @(negedge clk);
    arm = 1'b1;
    sampleEn = 1'b0;
    trigPc = tp;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Present pc = 0,1,2,... (one per cycle) until done is seen; n = cycles presented
  task automatic run_cap(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      pc = i;
      instr = i ^ IXOR;
      sampleEn = 1'b1;
      cyc++;
      @(negedge clk);
    end
    sampleEn = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic rd(input string tag, input int idx, input logic [31:0] exp_pc, input bit valid);
    rdIdx = idx[2:0];
    @(negedge clk);
    chk({tag, "_pc"}, rdPc, valid ? exp_pc : 32'd0);
    chk({tag, "_in"}, rdInstr, valid ? (exp_pc ^ IXOR) : 32'd0);
  endtask

  task automatic chk_status(input string tag, input int c, input int tp, input bit tmo);
    chk({tag, "_count"}, {28'd0, count}, c);
    chk({tag, "_trigpos"}, {29'd0, trigPos}, tp);
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, tmo});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; arm = 1'b0; sampleEn = 1'b1; pc = 32'd7; instr = 32'd9;
    trigPc = 32'd7; rdIdx = 3'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_rdpc", rdPc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_count", {28'd0, count}, 32'd0);

    // Trigger at pc 5, three post samples: pc 0..8 stored, oldest pc 1
    do_arm(32'd5);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    run_cap("t1", n);
    chk("t1_cycles", n, 32'd9);
    chk_status("t1", 8, 4, 1'b0);
    rd("t1_r0", 0, 32'd1, 1'b1);
    rd("t1_r4", 4, 32'd5, 1'b1);
    rd("t1_r7", 7, 32'd8, 1'b1);

    // No trigger: timeout 20 cycles after arm, pc 12..19 retained
    do_arm(32'd1000);
    run_cap("t2", n);
    chk("t2_cycles", n, 32'd20);
    chk_status("t2", 8, 0, 1'b1);
    rd("t2_r0", 0, 32'd12, 1'b1);
    rd("t2_r7", 7, 32'd19, 1'b1);

    // Trigger at first sample: pc 0..3 stored
    do_arm(32'd0);
    run_cap("t3", n);
    chk("t3_cycles", n, 32'd4);
    chk_status("t3", 4, 0, 1'b0);
    rd("t3_r0", 0, 32'd0, 1'b1);
    rd("t3_r3", 3, 32'd3, 1'b1);
    rd("t3_r5", 5, 32'd0, 1'b0);

    // Trigger at pc 17, timeout after two post samples: trigger entry at index 5
    do_arm(32'd17);
    run_cap("t4", n);
    chk("t4_cycles", n, 32'd20);
    chk_status("t4", 8, 5, 1'b1);
    rd("t4_r5", 5, 32'd17, 1'b1);

    // Trigger at pc 16: completion coincides with timeout cycle, completion wins
    do_arm(32'd16);
    run_cap("t5", n);
    chk("t5_cycles", n, 32'd20);
    chk_status("t5", 8, 4, 1'b0);
    rd("t5_r4", 4, 32'd16, 1'b1);

    // sampleEn toggling: only pc 0 and 2 stored
    do_arm(32'd1000);
    for (int i = 0; i < 4; i++) begin
      pc = i; instr = i ^ IXOR; sampleEn = (i % 2 == 0);
      @(negedge clk);
    end
    sampleEn = 1'b0;
    chk("t6_count", {28'd0, count}, 32'd2);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    rd("t6_r0", 0, 32'd0, 1'b1);
    rd("t6_r1", 1, 32'd2, 1'b1);
    rd("t6_r2", 2, 32'd0, 1'b0);

    // Re-arm while in POST
    do_arm(32'd2);
    for (int i = 0; i < 4; i++) begin
      pc = i; instr = i ^ IXOR; sampleEn = 1'b1;
      @(negedge clk);
    end
    sampleEn = 1'b0;
    chk("t7_pre_count", {28'd0, count}, 32'd4);
    do_arm(32'd1000);
    chk("t7_busy", {31'd0, busy}, 32'd1);
    chk("t7_done", {31'd0, done}, 32'd0);
    chk("t7_count", {28'd0, count}, 32'd0);
    chk("t7_trigpos", {29'd0, trigPos}, 32'd0);

    // Reset mid-ARMED aborts; block stays IDLE afterwards
    pc = 32'd50; sampleEn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t8_pre_count", {28'd0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t8_count", {28'd0, count}, 32'd0);
    chk("t8_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t8_idle_busy", {31'd0, busy}, 32'd0);
    chk("t8_idle_done", {31'd0, done}, 32'd0);
    chk("t8_idle_count", {28'd0, count}, 32'd0);
    rd("t8_r0", 0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_trace_buffer.md
SM_TRACE_BUFFER -- requirements
Module: sm_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace entries (power of two, 4..256); AW = log2(DEPTH).
REQ-002 SHALL have parameter POST_TRIG, default 8, meaning samples captured after the trigger sample (0..DEPTH-1).
REQ-003 SHALL have parameter TIMEOUT, default 120, meaning capture-window length in clk cycles (1..2^16-1).
REQ-004 SHALL have clk  input  1  system clock, all state updated on rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have arm  input  1  single-cycle pulse that clears and starts a capture.
REQ-007 SHALL have sampleEn  input  1  CPU-clock-enable qualifier; a sample is taken only when high.
REQ-008 SHALL have pc  input  32  CPU program counter (word index).
REQ-009 SHALL have instr  input  32  instruction at pc.
REQ-010 SHALL have trigPc  input  32  trigger program-counter value.
REQ-011 SHALL have rdIdx  input  AW  readout index, 0 = oldest stored entry.
REQ-012 SHALL have rdPc  output  32  pc of entry rdIdx.
REQ-013 SHALL have rdInstr  output  32  instr of entry rdIdx.
REQ-014 SHALL have count  output  AW+1  valid entries stored, 0..DEPTH.
REQ-015 SHALL have trigPos  output  AW  oldest-relative index of the trigger entry.
REQ-016 SHALL have busy  output  1  high in ARMED or POST.
REQ-017 SHALL have done  output  1  high in DONE.
REQ-018 SHALL have timeout  output  1  capture ended by TIMEOUT, not by trigger.

Function
REQ-019 SHALL implement states IDLE, ARMED, POST, DONE.
REQ-020 arm in any state SHALL, next cycle: enter ARMED, clear write pointer, count, cycle counter, timeout, trigPos; arm overrides every other event that cycle.
REQ-021 In ARMED/POST, a cycle with sampleEn high SHALL write {pc,instr} at the write pointer, advance it modulo DEPTH (wrap overwrites oldest), increment count saturating at DEPTH.
REQ-022 In ARMED, a sample with pc == trigPc SHALL be stored, then state goes POST with post counter = POST_TRIG; if POST_TRIG = 0, state goes DONE directly.
REQ-023 In POST, each stored sample SHALL decrement the post counter; the sample that makes it 0 SHALL be stored and state goes DONE next cycle.
REQ-024 Cycle counter SHALL increment every clk cycle in ARMED/POST regardless of sampleEn; on the cycle it equals TIMEOUT-1 without completion, state SHALL go DONE with timeout = 1 (that cycle's sample is still stored).
REQ-025 Completion and timeout in the same cycle SHALL resolve as completion: timeout = 0.
REQ-026 On entering DONE by trigger, trigPos SHALL equal count-1-POST_TRIG (final count); on timeout with trigger seen, count-1-(samples taken after trigger); no trigger seen: 0.
REQ-027 In IDLE and DONE, no samples SHALL be written and cycle counter SHALL hold.
REQ-028 rdPc/rdInstr SHALL be registered, 1-cycle latency from rdIdx; physical address = (wrPtr - count + rdIdx) mod DEPTH.
REQ-029 rdIdx >= count SHALL return rdPc = rdInstr = 0.
REQ-030 Readout SHALL be legal in every state; in ARMED/POST it returns live content, including an entry written the same cycle only from the next cycle.
REQ-031 busy, done, timeout, count, trigPos SHALL be registered outputs.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, count = 0, trigPos = 0, busy = done = timeout = 0, rdPc = rdInstr = 0, pointers and counters 0; storage contents need not clear but SHALL be unreadable since count = 0.
REQ-033 Reset asserted mid-capture SHALL abort it; after release the block stays IDLE until arm.

Verification (DEPTH=8, POST_TRIG=3, TIMEOUT=20)
REQ-034 Reset with any prior state -> all outputs 0, busy = 0, done = 0.
REQ-035 arm, sampleEn = 1, pc = 0,1,2,... , trigPc = 5 -> DONE after pc = 8 stored; count = 8, trigPos = 4, rdIdx 0 -> pc 1, rdIdx 7 -> pc 8, timeout = 0.
REQ-036 arm, trigPc never matched -> done at cycle 20 after arm, timeout = 1, count = 8, trigPos = 0, rdIdx 0 -> pc 12.
REQ-037 trigPc = 0, first sample pc = 0 -> DONE after pc = 3; count = 4, trigPos = 0, rdIdx 5 -> 0.
REQ-038 sampleEn toggling 1,0,1,0 with pc 0,1,2,3 -> only pc 0 and 2 stored, count = 2.
REQ-039 arm re-pulsed while POST -> next cycle ARMED, count = 0, busy = 1, done = 0; rst_n pulsed mid-ARMED -> IDLE, count = 0.
